// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: program start/stall control, instruction memory port,
// decoded branch request and branch-target table write port.
interface fetch_unit_if;
  logic       Start;
  logic       Stall;
  logic [8:0] InstData;
  logic [9:0] InstAddr;
  logic [8:0] Instr;
  logic       InstrValid;
  logic [1:0] Branch;
  logic       CondFlag;
  logic       LutWe;
  logic [4:0] LutIdx;
  logic [9:0] LutData;
  logic       Done;

  modport master (
    output Start, Stall, InstData, Branch, CondFlag, LutWe, LutIdx, LutData,
    input  InstAddr, Instr, InstrValid, Done
  );

  modport slave (
    input  Start, Stall, InstData, Branch, CondFlag, LutWe, LutIdx, LutData,
    output InstAddr, Instr, InstrValid, Done
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (IDLE/RUN/HALT) with a 32-entry branch-target table.
// Fetch latency 1 cycle, taken branch costs one bubble; Stall freezes PC/Instr/state.
module fetch_unit (
  input  logic         Clk,
  input  logic         Reset,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [8:0] NOP_WORD  = 9'b010000001;
  localparam logic [8:0] HALT_WORD = 9'b111111111;

  state_t     state;
  logic [9:0] pc;
  logic [8:0] instr;
  logic       instr_valid;
  logic       done;
  logic [9:0] lut [32];

  logic       cond_ok;
  logic       taken;
  logic       halt_hit;
  logic [9:0] target;

  // Table writes are independent of FSM state and Stall.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) lut[i] <= '0;
    end else if (bus.LutWe) begin
      lut[bus.LutIdx] <= bus.LutData;
    end
  end

  always_comb begin
    cond_ok = 1'b0;
    case (bus.Branch)
      2'b11:   cond_ok = 1'b1;
      2'b01:   cond_ok = bus.CondFlag;
      2'b10:   cond_ok = ~bus.CondFlag;
      default: cond_ok = 1'b0;
    endcase
  end

  // A bubble never redirects or halts; the read sees the pre-write table value.
  assign taken    = instr_valid && cond_ok;
  assign halt_hit = instr_valid && (instr == HALT_WORD);
  assign target   = lut[instr[4:0]];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            state       <= RUN;
            pc          <= '0;
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.Stall) begin
            if (halt_hit) begin
              state       <= HALT;
              instr       <= NOP_WORD;
              instr_valid <= 1'b0;
              done        <= 1'b1;
            end else if (taken) begin
              pc          <= target;
              instr       <= NOP_WORD;
              instr_valid <= 1'b0;
            end else begin
              instr       <= bus.InstData;
              instr_valid <= 1'b1;
              pc          <= pc + 10'd1;
            end
          end
        end
        HALT: begin
          if (bus.Start && !bus.Stall) begin
            state <= RUN;
            pc    <= '0;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.InstAddr   = pc;
  assign bus.Instr      = instr;
  assign bus.InstrValid = instr_valid;
  assign bus.Done       = done;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic against a cycle-level reference model of the fetch rules.
module tb_fetch_unit;

  localparam logic [8:0] NOP  = 9'b010000001;
  localparam logic [8:0] HALT = 9'b111111111;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  fetch_unit_if bus ();

  fetch_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  logic [8:0] mem [1024];
  assign bus.InstData = mem[bus.InstAddr];

  wire [20:0] obs = {bus.InstAddr, bus.Instr, bus.InstrValid, bus.Done};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: program counter, instruction register, mode.
  logic [9:0] m_pc;
  logic [8:0] m_instr;
  logic       m_valid;
  int         m_mode;   // 0 idle, 1 running, 2 halted
  logic [9:0] m_lut [32];

  function automatic logic [20:0] st(input logic [9:0] a, input logic [8:0] i,
                                     input logic v, input logic d);
    return {a, i, v, d};
  endfunction

  function automatic void model_step();
    logic [9:0] tgt;
    logic       jump;
    tgt  = m_lut[m_instr[4:0]];
    jump = m_valid && ((bus.Branch == 2'b11) ||
                       (bus.Branch == 2'b01 && bus.CondFlag) ||
                       (bus.Branch == 2'b10 && !bus.CondFlag));
    if (bus.LutWe) m_lut[bus.LutIdx] = bus.LutData;
    if (m_mode == 0 || (m_mode == 2 && !bus.Stall)) begin
      if (bus.Start) begin
        m_mode = 1; m_pc = 0; m_instr = NOP; m_valid = 0;
      end
    end else if (m_mode == 1 && !bus.Stall) begin
      if (m_valid && m_instr == HALT) begin
        m_mode = 2; m_instr = NOP; m_valid = 0;
      end else if (jump) begin
        m_pc = tgt; m_instr = NOP; m_valid = 0;
      end else begin
        m_instr = mem[m_pc]; m_valid = 1; m_pc = 10'((m_pc + 1) % 1024);
      end
    end
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    bus.Start = 0; bus.Stall = 0; bus.Branch = 2'b00; bus.CondFlag = 0;
    bus.LutWe = 0; bus.LutIdx = '0; bus.LutData = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    #2;
    Reset = 1'b1;
    m_pc = 0; m_instr = NOP; m_valid = 0; m_mode = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = '0;
  endtask

  task automatic lut_write(input logic [4:0] idx, input logic [9:0] data);
    bus.LutWe = 1; bus.LutIdx = idx; bus.LutData = data;
    tick();
    bus.LutWe = 0;
  endtask

  task automatic test_reset();
    #1;
    do_reset();
    Reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== st(0, NOP, 0, 0)) begin
      n_fail++; $display("FAIL reset_state: addr/instr/valid/done got %h expected %h", obs, st(0, NOP, 0, 0));
    end
    bus.Start = 1;
    tick();
    n_checks++;
    if (obs !== st(0, NOP, 0, 0)) begin
      n_fail++; $display("FAIL reset_holds_on_start: got %h expected %h", obs, st(0, NOP, 0, 0));
    end
    bus.Start = 0;
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.Stall = k[0];
      tick();
      n_checks++;
      if (obs !== st(0, NOP, 0, 0)) begin
        n_fail++; $display("FAIL idle_until_start cycle %0d: got %h expected %h", k, obs, st(0, NOP, 0, 0));
      end
    end
    bus.Stall = 0;
  endtask

  task automatic test_seq_fetch();
    do_reset();
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h004; mem[4] = 9'h005;
    bus.Start = 1;
    tick();
    bus.Start = 0;
    n_checks++;
    if (obs !== st(0, NOP, 0, 0)) begin
      n_fail++; $display("FAIL seq_enter_run: got %h expected %h", obs, st(0, NOP, 0, 0));
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (obs !== st(10'(k), 9'(k), 1, 0)) begin
        n_fail++; $display("FAIL seq_fetch step %0d: got %h expected %h", k, obs, st(10'(k), 9'(k), 1, 0));
      end
    end
  endtask

  task automatic test_uncond_jump();
    do_reset();
    lut_write(5'd5, 10'd100);
    mem[0] = 9'b110000101; mem[100] = 9'h0AB;
    bus.Start = 1; tick(); bus.Start = 0;
    tick();
    n_checks++;
    if (obs !== st(1, 9'h185, 1, 0)) begin
      n_fail++; $display("FAIL jump_setup: got %h expected %h", obs, st(1, 9'h185, 1, 0));
    end
    bus.Branch = 2'b11;
    tick();
    bus.Branch = 2'b00;
    n_checks++;
    if (obs !== st(100, NOP, 0, 0)) begin
      n_fail++; $display("FAIL jump_bubble: got %h expected %h", obs, st(100, NOP, 0, 0));
    end
    tick();
    n_checks++;
    if (obs !== st(101, 9'h0AB, 1, 0)) begin
      n_fail++; $display("FAIL jump_target_fetch: got %h expected %h", obs, st(101, 9'h0AB, 1, 0));
    end
  endtask

  task automatic test_cond_branch();
    do_reset();
    lut_write(5'd7, 10'd200);
    mem[0] = 9'h007; mem[1] = 9'h007; mem[200] = 9'h033;
    bus.Start = 1; tick(); bus.Start = 0;
    tick();
    bus.Branch = 2'b01; bus.CondFlag = 0;
    tick();
    n_checks++;
    if (obs !== st(2, 9'h007, 1, 0)) begin
      n_fail++; $display("FAIL cond01_not_taken: got %h expected %h", obs, st(2, 9'h007, 1, 0));
    end
    // Same-cycle table write to the branch index must not affect this redirect.
    bus.Branch = 2'b10; bus.CondFlag = 0;
    bus.LutWe = 1; bus.LutIdx = 5'd7; bus.LutData = 10'd222;
    tick();
    bus.Branch = 2'b00; bus.LutWe = 0;
    n_checks++;
    if (obs !== st(200, NOP, 0, 0)) begin
      n_fail++; $display("FAIL cond10_taken_old_lut: got %h expected %h", obs, st(200, NOP, 0, 0));
    end
    tick();
    n_checks++;
    if (obs !== st(201, 9'h033, 1, 0)) begin
      n_fail++; $display("FAIL cond10_target_fetch: got %h expected %h", obs, st(201, 9'h033, 1, 0));
    end
  endtask

  task automatic test_stall();
    do_reset();
    lut_write(5'd5, 10'd50);
    mem[0] = 9'h0C5; mem[300] = 9'h044;
    bus.Start = 1; tick(); bus.Start = 0;
    tick();
    bus.Branch = 2'b11; bus.Stall = 1;
    bus.LutWe = 1; bus.LutIdx = 5'd5; bus.LutData = 10'd300;
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.LutWe = 0;
      n_checks++;
      if (obs !== st(1, 9'h0C5, 1, 0)) begin
        n_fail++; $display("FAIL stall_hold cycle %0d: got %h expected %h", k, obs, st(1, 9'h0C5, 1, 0));
      end
    end
    bus.Stall = 0;
    tick();
    bus.Branch = 2'b00;
    n_checks++;
    if (obs !== st(300, NOP, 0, 0)) begin
      n_fail++; $display("FAIL stall_release_redirect: got %h expected %h", obs, st(300, NOP, 0, 0));
    end
    tick();
    n_checks++;
    if (obs !== st(301, 9'h044, 1, 0)) begin
      n_fail++; $display("FAIL stall_target_fetch: got %h expected %h", obs, st(301, 9'h044, 1, 0));
    end
  endtask

  task automatic test_halt_restart();
    do_reset();
    lut_write(5'd31, 10'd500);
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = HALT; mem[3] = 9'h005;
    bus.Start = 1; tick(); bus.Start = 0;
    tick(); tick(); tick();
    n_checks++;
    if (obs !== st(3, HALT, 1, 0)) begin
      n_fail++; $display("FAIL halt_word_fetched: got %h expected %h", obs, st(3, HALT, 1, 0));
    end
    bus.Branch = 2'b11;
    tick();
    bus.Branch = 2'b00;
    n_checks++;
    if (obs !== st(3, NOP, 0, 1)) begin
      n_fail++; $display("FAIL halt_done_over_branch: got %h expected %h", obs, st(3, NOP, 0, 1));
    end
    tick();
    n_checks++;
    if (obs !== st(3, NOP, 0, 1)) begin
      n_fail++; $display("FAIL halt_holds: got %h expected %h", obs, st(3, NOP, 0, 1));
    end
    bus.Start = 1; tick(); bus.Start = 0;
    n_checks++;
    if (obs !== st(0, NOP, 0, 0)) begin
      n_fail++; $display("FAIL halt_restart: got %h expected %h", obs, st(0, NOP, 0, 0));
    end
    tick();
    n_checks++;
    if (obs !== st(1, 9'h001, 1, 0)) begin
      n_fail++; $display("FAIL restart_fetch: got %h expected %h", obs, st(1, 9'h001, 1, 0));
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    lut_write(5'd1, 10'd1023);
    mem[0] = 9'h0C1; mem[1023] = 9'h010;
    bus.Start = 1; tick(); bus.Start = 0;
    tick();
    bus.Branch = 2'b11; tick(); bus.Branch = 2'b00;
    n_checks++;
    if (obs !== st(1023, NOP, 0, 0)) begin
      n_fail++; $display("FAIL wrap_at_1023: got %h expected %h", obs, st(1023, NOP, 0, 0));
    end
    tick();
    n_checks++;
    if (obs !== st(0, 9'h010, 1, 0)) begin
      n_fail++; $display("FAIL wrap_to_0: got %h expected %h", obs, st(0, 9'h010, 1, 0));
    end
    lut_write(5'd5, 10'd77);
    #3;
    Reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== st(0, NOP, 0, 0)) begin
      n_fail++; $display("FAIL async_reset_midrun: got %h expected %h", obs, st(0, NOP, 0, 0));
    end
    #1;
    Reset = 1'b1;
    mem[0] = 9'h0C5;
    tick();
    n_checks++;
    if (obs !== st(0, NOP, 0, 0)) begin
      n_fail++; $display("FAIL idle_after_reset: got %h expected %h", obs, st(0, NOP, 0, 0));
    end
    bus.Start = 1; tick(); bus.Start = 0;
    tick();
    bus.Branch = 2'b11; tick(); bus.Branch = 2'b00;
    n_checks++;
    if (obs !== st(0, NOP, 0, 0)) begin
      n_fail++; $display("FAIL lut5_cleared_by_reset: got %h expected %h", obs, st(0, NOP, 0, 0));
    end
  endtask

  task automatic test_random();
    logic [20:0] exp_v;
    do_reset();
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 40) == 0) ? HALT : 9'($urandom);
    for (int c = 0; c < 4000; c++) begin
      bus.Start    = ($urandom_range(0, 15) == 0);
      bus.Stall    = (m_mode == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
      bus.Branch   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      bus.CondFlag = 1'($urandom);
      bus.LutWe    = ($urandom_range(0, 2) == 0);
      bus.LutIdx   = ($urandom_range(0, 1) == 0) ? m_instr[4:0] : 5'($urandom);
      bus.LutData  = 10'($urandom);
      model_step();
      tick();
      exp_v = st(m_pc, m_instr, m_valid, m_mode == 2);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random cycle %0d: got %h expected %h", c, obs, exp_v);
      end
    end
    bus.Start = 0; bus.Stall = 0; bus.Branch = 2'b00; bus.LutWe = 0;
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_uncond_jump();
    test_cond_branch();
    test_stall();
    test_halt_restart();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL expose `Clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL expose `Reset`, input, 1 bit: asynchronous, active-low reset; asserting it (0) clears state immediately, independent of `Clk`.
REQ-003 The module SHALL expose `Start`, input, 1 bit: a one-cycle pulse that begins program execution at address 0.
REQ-004 The module SHALL expose `Stall`, input, 1 bit: while 1, `PC`, `Instr`, `InstrValid` and the FSM state all hold.
REQ-005 The module SHALL expose `InstData`, input, 9 bits: the instruction word, read combinationally from instruction memory at `InstAddr`.
REQ-006 The module SHALL expose `InstAddr`, output, 10 bits: the current PC.
REQ-007 The module SHALL expose `Instr`, output, 9 bits: the registered instruction presented to the control decoder.
REQ-008 The module SHALL expose `InstrValid`, output, 1 bit: 1 when `Instr` holds a real fetched instruction, 0 when it holds a bubble.
REQ-009 The module SHALL expose `Branch`, input, 2 bits, driven by the decoder from `Instr`, with encodings 00 none, 11 unconditional jump, 01 jump if `CondFlag`=1, 10 jump if `CondFlag`=0.
REQ-010 The module SHALL expose `CondFlag`, input, 1 bit: the ALU condition flag.
REQ-011 The module SHALL expose `LutWe`, input, 1 bit; `LutIdx`, input, 5 bits; and `LutData`, input, 10 bits: the branch-target table write port.
REQ-012 The module SHALL expose `Done`, output, 1 bit: 1 while in the HALT state.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and HALT.
REQ-014 The NOP bubble SHALL be 9'b010000001.
REQ-015 The HALT word SHALL be 9'b111111111.
REQ-016 In IDLE, `Start`=1 SHALL cause the next state to be RUN, with PC=0, `Instr`=NOP and `InstrValid`=0.
REQ-017 In IDLE, `Stall` SHALL be ignored.
REQ-018 In RUN, when `Stall`=0 and no branch is taken, each cycle SHALL perform `Instr`<=`InstData`, `InstrValid`<=1 and PC<=PC+1.
REQ-019 The first valid `Instr` SHALL appear one cycle after entering RUN, i.e. a fetch latency of 1 cycle.
REQ-020 PC increment SHALL be modulo 1024, so 1023 wraps to 0 with no flag raised.
REQ-021 A branch SHALL be taken when `InstrValid`=1 and either `Branch`=11, or `Branch`=01 with `CondFlag`=1, or `Branch`=10 with `CondFlag`=0.
REQ-022 A taken branch with `Stall`=0 SHALL perform PC<=LUT[`Instr`[4:0]], `Instr`<=NOP and `InstrValid`<=0, squashing the sequential fetch.
REQ-023 Every taken branch SHALL cost exactly one bubble cycle.
REQ-024 `Branch` and `CondFlag` SHALL be ignored when `InstrValid`=0, so a bubble never redirects.
REQ-025 When `Stall`=1, all registers SHALL hold.
REQ-026 A pending branch or halt SHALL be evaluated on the first cycle with `Stall`=0.
REQ-027 When `Instr`=HALT, `InstrValid`=1 and `Stall`=0, the FSM SHALL transition to HALT with `Instr`<=NOP, `InstrValid`<=0 and PC held.
REQ-028 HALT detection SHALL take priority over `Branch`.
REQ-029 In HALT, `Done`=1 and `Start`=1 SHALL transition the FSM to RUN with PC=0 and `Done` deasserting next cycle.
REQ-030 `Start` SHALL be ignored while in RUN.
REQ-031 The LUT SHALL be 32 entries × 10 bits and written on a clock edge when `LutWe`=1.
REQ-032 LUT writes SHALL be accepted in every state, including during `Stall`.
REQ-033 A LUT read SHALL be combinational.
REQ-034 A same-cycle write and branch read to the same index SHALL return the old value.

Reset
REQ-035 While `Reset`=0, the module SHALL hold state=IDLE, PC=0, `Instr`=NOP, `InstrValid`=0, `Done`=0 and all LUT entries=0.
REQ-036 Reset asserted mid-RUN SHALL abort immediately, with no completion of the in-flight fetch.
REQ-037 After `Reset` deasserts, the module SHALL remain in IDLE until `Start`.

Verification
REQ-038 The bench SHALL cover sequential fetch: memory[0..3]=9'h001,9'h002,9'h003,9'h004, pulse `Start` -> `Instr` shows 001..004 on consecutive cycles, `InstAddr` 0,1,2,3,4, and `InstrValid` goes high one cycle after `Start`.
REQ-039 The bench SHALL cover unconditional jump: LUT[5]=10'd100, `Instr`=9'b110000101 with `Branch`=11 -> next cycle `InstAddr`=100 and `Instr`=NOP with `InstrValid`=0, then the next cycle `Instr`=memory[100].
REQ-040 The bench SHALL cover conditional branches: `Branch`=01 with `CondFlag`=0 -> no redirect and PC+1; `Branch`=10 with `CondFlag`=0 -> redirect to the LUT target.
REQ-041 The bench SHALL cover stall: `Stall`=1 for 3 cycles while `Branch`=11 on a valid `Instr` -> `InstAddr`, `Instr` and `InstrValid` frozen, then redirect on the first cycle with `Stall`=0.
REQ-042 The bench SHALL cover halt and restart: memory[2]=9'h1FF -> `Done`=1 two cycles after address 2 is fetched, and `InstAddr` held; then pulse `Start` -> `InstAddr`=0 and `Done`=0 next cycle.
REQ-043 The bench SHALL cover wrap and reset: run with PC=1023 -> next PC=0; then assert `Reset` asynchronously mid-cycle -> `InstrValid`, `Done` and PC=0 immediately, and LUT[5] reads 0.
